mill_modif_rx_ctrl: RTL and testbench
=====================================

Name: mill_modif_rx_ctrl

Overview:
- Receive-side sequencer for the ISO 14443A Miller-modified decoder.
- Watches the synchronized carrier/pause line and detects SOF and EOF. Drives the decoder's enable for exactly one frame.
- Packs the decoded bit stream into bytes and checks odd parity.
- Hands bytes to the protocol layer through a valid/ready FIFO and reports frame status.

Parameters:
ETU_CLKS, 32, clk cycles per ETU (fc/4 clock, 106 kb/s)
EOF_GAP, 64, carrier-on cycles after last pause that declare EOF (must exceed 1.5 ETU = 48)
MAX_BYTES, 32, maximum bytes per frame
FIFO_DEPTH, 4, output byte FIFO entries (power of 2)

Ports:
clk  in  1  fc/4 clock (3.39 MHz)
in_PoR  in  1  power-on reset, asynchronous, active-low
in_data  in  1  raw field line: 1 = carrier, 0 = pause
in_rx_arm  in  1  level; 1 = allowed to start a new frame
in_bit_valid  in  1  one-cycle strobe from decoder: new decoded bit
in_bit  in  1  decoded bit value
out_dec_enable  out  1  enable to the Miller-modified decoder
out_byte  out  8  received byte, LSB = first bit on air
out_byte_valid  out  1  FIFO not empty
in_byte_ready  in  1  consumer accepts out_byte this cycle
out_busy  out  1  frame in progress (state != IDLE)
out_frame_done  out  1  one-cycle pulse at end of frame
out_byte_cnt  out  $clog2(MAX_BYTES+1)  bytes in last frame
out_parity_err  out  1  sticky per frame: any byte failed odd parity
out_short_frame  out  1  frame was exactly 7 bits
out_frame_err  out  1  bit count not 7 and not a multiple of 9, or zero bits
out_overflow  out  1  byte dropped (FIFO full or > MAX_BYTES)

Behaviour:
- Reset (in_PoR=0, async): state IDLE, all outputs 0, FIFO emptied, counters cleared.
- Synchronizer: in_data passes a 2-flop synchronizer (in_sync). Any reference below to in_data means in_sync, 2-cycle latency.
- pause_fall = in_sync 1->0 edge. gap_cnt counts consecutive in_sync=1 cycles, is cleared on in_sync=0, and saturates at EOF_GAP.
- FSM:
  - IDLE: a pause_fall with in_rx_arm=1 goes to SOF. The status flags and out_byte_cnt of the previous frame clear on this transition.
  - SOF: wait for in_sync=1 (end of SOF pause), then go to RECV. out_dec_enable=1 from the first RECV cycle.
  - RECV: accept bits on in_bit_valid. gap_cnt==EOF_GAP goes to EOF; in_rx_arm=0 also goes to EOF (abort, sets out_frame_err).
  - EOF: out_dec_enable=0. Evaluate the partial byte and pulse out_frame_done for 1 cycle, then go to IDLE.
- out_dec_enable = 1 only in RECV; it drops the cycle gap_cnt reaches EOF_GAP.
- Bit packing: bit_idx 0..8.
  - Bits 0-7 shift into data LSB-first; bit 8 is the parity bit.
  - On bit 8: byte pushed if (XOR of 9 bits)==1; otherwise still pushed and out_parity_err set. bit_idx then wraps to 0.
  - total_bits is counted separately, saturating.
- EOF evaluation:
  - total_bits==7 and no byte completed: push {1'b0, 7 bits}, out_short_frame=1, out_byte_cnt=1.
  - total_bits==0 or bit_idx!=0 (other than the 7-bit case): out_frame_err=1; the partial byte is discarded.
- Push rules:
  - Push when FIFO not full and byte count < MAX_BYTES.
  - Otherwise drop, set out_overflow; out_byte_cnt is not incremented.
  - out_byte_cnt counts pushed bytes.
- FIFO handshake: first-word fall-through.
  - Pop when out_byte_valid && in_byte_ready.
  - Simultaneous push and pop when full is allowed: the pop frees the slot, no overflow.
  - Data is stable while valid && !ready.
  - Consumer may drain during RECV and after frame_done; the FIFO is not flushed between frames.
- Simultaneous events:
  - in_bit_valid on the cycle EOF is declared: the bit is accepted before evaluation.
  - pause_fall in EOF state: ignored; it can only start a new frame from IDLE.

Decomposition:
- Package mill_rx_pkg:
  - state enum {IDLE, SOF, RECV, EOF}
  - ETU_CLKS/EOF_GAP defaults
  - parity function
- Sub-module mill_rx_fifo: generic sync FIFO, DEPTH/WIDTH params, full/empty, FWFT, same clk/in_PoR.

Test Plan:
- 1-byte frame 0x26 (7-bit REQA): SOF pause, 7 decoder bits 0,1,1,0,0,1,0, then 64-cycle gap -> out_byte=0x26, out_short_frame=1, out_byte_cnt=1, out_frame_done pulse, out_dec_enable low after gap.
- 2-byte frame 0x93 0x20 with correct parity (18 bits) -> two bytes in order, out_parity_err=0, out_frame_err=0, out_byte_cnt=2.
- Same frame with the parity bit of byte 1 flipped -> both bytes delivered, out_parity_err=1.
- in_byte_ready held 0, 6-byte frame, FIFO_DEPTH=4 -> 4 bytes held, out_overflow=1, out_byte_cnt=4; then ready=1 drains exactly 4 bytes.
- 12 bits then EOF -> out_frame_err=1, 1 byte delivered.
- in_PoR low mid-RECV -> all outputs 0 immediately, FIFO empty; next SOF starts clean.
- in_rx_arm dropped mid-RECV -> frame_done with out_frame_err=1.

Source files
------------

// File: rtl/mill_rx_pkg.sv
// ----------------------------------------------------------------------------
// mill_rx_pkg
// Shared definitions for the ISO 14443A Miller-modified receive sequencer.
//   state_t        : sequencer states (IDLE, SOF, RECV, EOF)
//   *_DEF          : default timing / sizing parameters
//   odd_parity_ok  : 1 when the 8 data bits plus parity bit hold an odd
//                    number of ones
// ----------------------------------------------------------------------------
package mill_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    RECV = 2'd2,
    EOF  = 2'd3
  } state_t;

  localparam int ETU_CLKS_DEF   = 32;
  localparam int EOF_GAP_DEF    = 64;
  localparam int MAX_BYTES_DEF  = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/mill_rx_fifo.sv
// ----------------------------------------------------------------------------
// mill_rx_fifo
// Generic synchronous first-word-fall-through FIFO.
//   clk, in_PoR : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data this cycle (accepted when not full, or when
//                 a pop happens in the same cycle)
//   push_data   : write data
//   pop         : consume the head entry this cycle (ignored when empty)
//   pop_data    : head entry, valid while !empty, forced to 0 when empty
//   full, empty : occupancy flags
// ----------------------------------------------------------------------------
module mill_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             in_PoR,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still taken when the head leaves simultaneously.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge in_PoR) begin
    if (!in_PoR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pop_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mill_modif_rx_ctrl.sv
// ----------------------------------------------------------------------------
// mill_modif_rx_ctrl
// Receive-side sequencer for the ISO 14443A Miller-modified decoder.
// Detects SOF/EOF on the synchronized field line, enables the decoder for
// exactly one frame, packs decoded bits into bytes with odd-parity checking
// and hands bytes out through a FWFT FIFO.
//
// Ports
//   clk             fc/4 clock
//   in_PoR          asynchronous active-low power-on reset
//   in_data         raw field line (1 = carrier, 0 = pause)
//   in_rx_arm       1 = a new frame may start; 0 during RECV aborts the frame
//   in_bit_valid    decoder strobe, in_bit holds the decoded bit
//   out_dec_enable  decoder enable, high only while receiving
//   out_byte        head byte of the FIFO, LSB = first bit on air
//   out_byte_valid  FIFO not empty
//   in_byte_ready   consumer accepts out_byte this cycle
//   out_busy        frame in progress
//   out_frame_done  one-cycle pulse when the frame status is final
//   out_byte_cnt    bytes pushed in the last frame
//   out_parity_err  some byte of the frame failed odd parity
//   out_short_frame frame was exactly 7 bits
//   out_frame_err   malformed or aborted frame
//   out_overflow    a byte was dropped (FIFO full or frame too long)
//   dbg_state       current sequencer state
//
// Byte handshake: a byte transfers on every cycle where out_byte_valid and
// in_byte_ready are both high. While out_byte_valid is high and in_byte_ready
// is low, out_byte holds its value; out_byte_valid never drops without a pop.
// ----------------------------------------------------------------------------
module mill_modif_rx_ctrl
  import mill_rx_pkg::*;
#(
  parameter int ETU_CLKS   = ETU_CLKS_DEF,
  parameter int EOF_GAP    = EOF_GAP_DEF,
  parameter int MAX_BYTES  = MAX_BYTES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           in_PoR,
  input  logic                           in_data,
  input  logic                           in_rx_arm,
  input  logic                           in_bit_valid,
  input  logic                           in_bit,
  output logic                           out_dec_enable,
  output logic [7:0]                     out_byte,
  output logic                           out_byte_valid,
  input  logic                           in_byte_ready,
  output logic                           out_busy,
  output logic                           out_frame_done,
  output logic [$clog2(MAX_BYTES+1)-1:0] out_byte_cnt,
  output logic                           out_parity_err,
  output logic                           out_short_frame,
  output logic                           out_frame_err,
  output logic                           out_overflow,
  output state_t                         dbg_state
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  // The EOF gap must be longer than the longest legal carrier run inside a
  // frame (1.5 ETU); fall back to 2 ETU if configured too small.
  localparam int EOF_GAP_EFF = (EOF_GAP * 2 > ETU_CLKS * 3) ? EOF_GAP : ETU_CLKS * 2;
  localparam int GAP_W = $clog2(EOF_GAP_EFF + 1);
  localparam int TB_W  = $clog2(MAX_BYTES * 9 + 1) + 1;

  // --------------------------------------------------------------------------
  // Line synchronizer and gap counter
  // --------------------------------------------------------------------------
  logic             sync_meta;
  logic             in_sync;
  logic             in_sync_d;
  logic             pause_fall;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;

  // Resetting to 1 (carrier) keeps reset release from looking like a pause.
  always_ff @(posedge clk or negedge in_PoR) begin
    if (!in_PoR) begin
      sync_meta <= 1'b1;
      in_sync   <= 1'b1;
      in_sync_d <= 1'b1;
    end else begin
      sync_meta <= in_data;
      in_sync   <= sync_meta;
      in_sync_d <= in_sync;
    end
  end

  assign pause_fall = in_sync_d && !in_sync;

  always_comb begin
    gap_nxt = gap_cnt;
    if (!in_sync)                               gap_nxt = '0;
    else if (gap_cnt != GAP_W'(EOF_GAP_EFF))    gap_nxt = gap_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge in_PoR) begin
    if (!in_PoR) gap_cnt <= '0;
    else         gap_cnt <= gap_nxt;
  end

  // --------------------------------------------------------------------------
  // Byte push arbitration
  // --------------------------------------------------------------------------
  state_t            state;
  logic [7:0]        data;
  logic [3:0]        bit_idx;
  logic [TB_W-1:0]   total_bits;
  logic              abort;
  logic              push_req;
  logic [7:0]        push_byte;
  logic              push_ok;
  logic              push_drop;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              is_short;

  // Exactly 7 bits and no completed byte: the REQA/WUPA short frame.
  assign is_short = (total_bits == TB_W'(7)) && (bit_idx == 4'd7);

  always_comb begin
    push_req  = 1'b0;
    push_byte = data;
    if (state == RECV && in_bit_valid && bit_idx == 4'd8) begin
      push_req = 1'b1;
    end else if (state == EOF && is_short) begin
      push_req  = 1'b1;
      push_byte = {1'b0, data[6:0]};
    end
  end

  assign fifo_pop  = out_byte_valid && in_byte_ready;
  assign push_ok   = push_req && (!fifo_full || fifo_pop) &&
                     (out_byte_cnt < CNT_W'(MAX_BYTES));
  assign push_drop = push_req && !push_ok;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge in_PoR) begin
    if (!in_PoR) begin
      state           <= IDLE;
      data            <= '0;
      bit_idx         <= '0;
      total_bits      <= '0;
      abort           <= 1'b0;
      out_dec_enable  <= 1'b0;
      out_frame_done  <= 1'b0;
      out_byte_cnt    <= '0;
      out_parity_err  <= 1'b0;
      out_short_frame <= 1'b0;
      out_frame_err   <= 1'b0;
      out_overflow    <= 1'b0;
    end else begin
      out_frame_done <= 1'b0;
      if (push_ok)   out_byte_cnt <= out_byte_cnt + 1'b1;
      if (push_drop) out_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pause_fall && in_rx_arm) begin
            state           <= SOF;
            data            <= '0;
            bit_idx         <= '0;
            total_bits      <= '0;
            abort           <= 1'b0;
            out_byte_cnt    <= '0;
            out_parity_err  <= 1'b0;
            out_short_frame <= 1'b0;
            out_frame_err   <= 1'b0;
            out_overflow    <= 1'b0;
          end
        end

        SOF: begin
          if (in_sync) begin
            state          <= RECV;
            out_dec_enable <= 1'b1;
          end
        end

        RECV: begin
          // A bit arriving in the same cycle EOF is declared is still taken.
          if (in_bit_valid) begin
            if (total_bits != '1) total_bits <= total_bits + 1'b1;
            if (bit_idx == 4'd8) begin
              bit_idx <= '0;
              if (!odd_parity_ok(data, in_bit)) out_parity_err <= 1'b1;
            end else begin
              data[bit_idx[2:0]] <= in_bit;
              bit_idx            <= bit_idx + 1'b1;
            end
          end
          // Looking at gap_nxt makes the enable drop in the very cycle the
          // gap counter reaches its threshold.
          if (gap_nxt == GAP_W'(EOF_GAP_EFF)) begin
            state          <= EOF;
            out_dec_enable <= 1'b0;
          end else if (!in_rx_arm) begin
            state          <= EOF;
            out_dec_enable <= 1'b0;
            abort          <= 1'b1;
          end
        end

        EOF: begin
          state          <= IDLE;
          out_frame_done <= 1'b1;
          if (abort) out_frame_err <= 1'b1;
          if (is_short) begin
            out_short_frame <= 1'b1;
          end else if (total_bits == '0 || bit_idx != 4'd0) begin
            out_frame_err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign out_busy       = (state != IDLE);
  assign dbg_state      = state;
  assign out_byte_valid = !fifo_empty;

  // --------------------------------------------------------------------------
  // Output byte FIFO
  // --------------------------------------------------------------------------
  mill_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .in_PoR    (in_PoR),
    .push      (push_ok),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .pop_data  (out_byte),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_mill_modif_rx_ctrl.sv
`timescale 1ns/1ps
module tb_mill_modif_rx_ctrl;
  import mill_rx_pkg::*;

  localparam int MAX_BYTES  = 32;
  localparam int FIFO_DEPTH = 4;

  // --------------------------------------------------------------------------
  // Clock / reset block and DUT
  // --------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       in_PoR;
  logic       in_data;
  logic       in_rx_arm;
  logic       in_bit_valid;
  logic       in_bit;
  logic       in_byte_ready;
  logic       out_dec_enable;
  logic [7:0] out_byte;
  logic       out_byte_valid;
  logic       out_busy;
  logic       out_frame_done;
  logic [5:0] out_byte_cnt;
  logic       out_parity_err;
  logic       out_short_frame;
  logic       out_frame_err;
  logic       out_overflow;
  state_t     dbg_state;

  always #5 clk = ~clk;

  mill_modif_rx_ctrl #(
    .ETU_CLKS   (32),
    .EOF_GAP    (64),
    .MAX_BYTES  (MAX_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .in_PoR          (in_PoR),
    .in_data         (in_data),
    .in_rx_arm       (in_rx_arm),
    .in_bit_valid    (in_bit_valid),
    .in_bit          (in_bit),
    .out_dec_enable  (out_dec_enable),
    .out_byte        (out_byte),
    .out_byte_valid  (out_byte_valid),
    .in_byte_ready   (in_byte_ready),
    .out_busy        (out_busy),
    .out_frame_done  (out_frame_done),
    .out_byte_cnt    (out_byte_cnt),
    .out_parity_err  (out_parity_err),
    .out_short_frame (out_short_frame),
    .out_frame_err   (out_frame_err),
    .out_overflow    (out_overflow),
    .dbg_state       (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic       bits_q[$];
  int         popped_cnt = 0;
  int         exp_cnt;
  logic       exp_perr, exp_short, exp_ferr, exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every accepted byte on the handshake is compared to the model queue.
  always @(negedge clk) begin
    if (in_PoR && out_byte_valid && in_byte_ready) begin
      popped_cnt++;
      if (exp_q.size() > 0) check("byte", out_byte, exp_q.pop_front());
    end
  end

  // Reference model: frame outcome straight from the bit list.
  task automatic model_frame(input bit abort, input bit hold);
    int n, nb, ones, cap, total;
    logic [7:0] b;
    logic [7:0] list[$];
    n         = bits_q.size();
    nb        = n / 9;
    exp_perr  = 1'b0;
    exp_short = (n == 7);
    if (exp_short) begin
      b = 8'h00;
      for (int k = 0; k < 7; k++) b[k] = bits_q[k];
      list.push_back(b);
    end else begin
      for (int j = 0; j < nb; j++) begin
        ones = 0;
        for (int k = 0; k < 8; k++) begin
          b[k] = bits_q[9*j+k];
          ones += int'(bits_q[9*j+k]);
        end
        ones += int'(bits_q[9*j+8]);
        if (ones % 2 == 0) exp_perr = 1'b1;
        list.push_back(b);
      end
    end
    exp_ferr = abort || (n == 0) || (!exp_short && (n % 9 != 0));
    cap      = hold ? FIFO_DEPTH : MAX_BYTES;
    total    = list.size();
    exp_cnt  = (total < cap) ? total : cap;
    exp_ovf  = (total > cap);
    for (int i = 0; i < exp_cnt; i++) exp_q.push_back(list[i]);
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] b, input bit flip);
    for (int k = 0; k < 8; k++) bits_q.push_back(b[k]);
    bits_q.push_back((~^b) ^ flip);
  endtask

  task automatic add_rand_bits(input int n);
    for (int k = 0; k < n; k++) bits_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic send_sof();
    in_data = 1'b0;
    repeat (8) tick();
    in_data = 1'b1;
    repeat (20) tick();
  endtask

  // One decoded bit per ~32 cycles with a pause in between, so the carrier
  // run never reaches the EOF gap inside the frame.
  task automatic send_bits();
    for (int i = 0; i < bits_q.size(); i++) begin
      in_bit       = bits_q[i];
      in_bit_valid = 1'b1;
      tick();
      in_bit_valid = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        check("dec_enable_recv", out_dec_enable, 1);
        check("busy_recv", out_busy, 1);
      end
      repeat (3) tick();
      in_data = 1'b0;
      repeat (8) tick();
      in_data = 1'b1;
      repeat (20) tick();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_dec_enable", out_dec_enable, 0);
    check("rst_byte", out_byte, 0);
    check("rst_byte_valid", out_byte_valid, 0);
    check("rst_busy", out_busy, 0);
    check("rst_frame_done", out_frame_done, 0);
    check("rst_byte_cnt", out_byte_cnt, 0);
    check("rst_parity_err", out_parity_err, 0);
    check("rst_short", out_short_frame, 0);
    check("rst_frame_err", out_frame_err, 0);
    check("rst_overflow", out_overflow, 0);
    check("rst_state", dbg_state, IDLE);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      in_byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_byte_valid) break;
      tick();
    end
    check("drain_empty", out_byte_valid, 0);
    check("pop_count", popped_cnt, exp_cnt);
  endtask

  task automatic run_frame(input bit abort, input bit hold);
    model_frame(abort, hold);
    popped_cnt    = 0;
    in_byte_ready = hold ? 1'b0 : 1'b1;
    send_sof();
    send_bits();
    if (abort) begin
      repeat (2) tick();
      in_rx_arm = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_frame_done) break;
    end
    check("frame_done", out_frame_done, 1);
    check("byte_cnt", out_byte_cnt, exp_cnt);
    check("parity_err", out_parity_err, exp_perr);
    check("short_frame", out_short_frame, exp_short);
    check("frame_err", out_frame_err, exp_ferr);
    check("overflow", out_overflow, exp_ovf);
    check("dec_enable_eof", out_dec_enable, 0);
    check("busy_done", out_busy, 0);
    in_rx_arm = 1'b1;
    tick();
    @(negedge clk);
    check("done_pulse", out_frame_done, 0);
    drain();
    repeat (10) tick();
  endtask

  task automatic reset_mid_frame();
    exp_q.delete();
    bits_q.delete();
    in_byte_ready = 1'b0;
    add_byte(8'hA5, 1'b0);
    add_rand_bits(5);
    send_sof();
    send_bits();
    in_PoR = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) tick();
    in_PoR = 1'b1;
    repeat (5) tick();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int kind, nbytes;
    bit hold;
    in_PoR        = 1'b0;
    in_data       = 1'b1;
    in_rx_arm     = 1'b1;
    in_bit_valid  = 1'b0;
    in_bit        = 1'b0;
    in_byte_ready = 1'b1;
    #1;
    check_reset_outputs();
    repeat (5) tick();
    in_PoR = 1'b1;
    repeat (5) tick();

    // REQA 0x26, 7 bits
    bits_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_frame(1'b0, 1'b0);

    // SEL 0x93 0x20, correct parity
    bits_q.delete();
    add_byte(8'h93, 1'b0);
    add_byte(8'h20, 1'b0);
    run_frame(1'b0, 1'b0);

    // same frame with byte 1 parity flipped
    bits_q.delete();
    add_byte(8'h93, 1'b1);
    add_byte(8'h20, 1'b0);
    run_frame(1'b0, 1'b0);

    // consumer stalled, 6 bytes into a 4-entry FIFO
    bits_q.delete();
    for (int i = 0; i < 6; i++) add_byte(8'($urandom_range(0, 255)), 1'b0);
    run_frame(1'b0, 1'b1);

    // 12 bits: one byte plus a 3-bit fragment
    bits_q.delete();
    add_byte(8'h5C, 1'b0);
    add_rand_bits(3);
    run_frame(1'b0, 1'b0);

    // reset in the middle of reception, then a clean frame
    reset_mid_frame();
    bits_q.delete();
    add_byte(8'h3C, 1'b0);
    run_frame(1'b0, 1'b0);

    // arm dropped mid-frame
    bits_q.delete();
    add_byte(8'hC3, 1'b0);
    add_rand_bits(4);
    run_frame(1'b1, 1'b0);

    // empty frame: SOF followed only by carrier
    bits_q.delete();
    run_frame(1'b0, 1'b0);

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      bits_q.delete();
      kind = $urandom_range(0, 3);
      hold = ($urandom_range(0, 3) == 0);
      case (kind)
        0: add_rand_bits(7);
        1: begin
          nbytes = $urandom_range(1, 5);
          for (int i = 0; i < nbytes; i++)
            add_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
        end
        2: add_rand_bits($urandom_range(0, 30));
        default: begin
          nbytes = $urandom_range(0, 3);
          for (int i = 0; i < nbytes; i++) add_byte(8'($urandom_range(0, 255)), 1'b0);
          add_rand_bits($urandom_range(0, 5));
          if (bits_q.size() == 7) add_rand_bits(1);
        end
      endcase
      run_frame(kind == 3, hold);
    end

    // longer than MAX_BYTES with a fast consumer
    bits_q.delete();
    for (int i = 0; i < MAX_BYTES + 2; i++) add_byte(8'($urandom_range(0, 255)), 1'b0);
    run_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
